// File: rtl/user_input_ctrl_pkg.sv
// Shared game types for the pushbutton front end: command encodings, controller
// FSM states, board key indices and the press-priority decoder.
package user_input_ctrl_pkg;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        HIT    = 3'd1,
        STAND  = 3'd2,
        DOUBLE = 3'd3,
        SPLIT  = 3'd4
    } gameCommand;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } uic_state_t;

    localparam int KEY_HIT    = 0;
    localparam int KEY_STAND  = 1;
    localparam int KEY_DOUBLE = 2;
    localparam int KEY_SPLIT  = 3;
    localparam int MAX_KEYS   = 4;

    function automatic int player_width(input int num_players);
        return (num_players > 1) ? $clog2(num_players) : 1;
    endfunction

    // STAND beats HIT so a fumbled two-key press never draws an extra card.
    function automatic gameCommand decode_press(input logic [MAX_KEYS-1:0] press);
        gameCommand cmd;
        cmd = NONE;
        if (press[KEY_STAND]) begin
            cmd = STAND;
        end else if (press[KEY_HIT]) begin
            cmd = HIT;
        end else if (press[KEY_DOUBLE]) begin
            cmd = DOUBLE;
        end else if (press[KEY_SPLIT]) begin
            cmd = SPLIT;
        end else begin
            cmd = NONE;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/user_input_ctrl_if.sv
// Command handshake between the pushbutton controller (master) and the
// dealer/turn FSM (slave).
interface user_input_ctrl_if
    import user_input_ctrl_pkg::*;
#(
    parameter int PLAYER_W = 1
);
    logic                turnIndicator;
    logic [PLAYER_W-1:0] activePlayer;
    logic                accept;
    logic                ready;
    gameCommand          command;
    logic [PLAYER_W-1:0] commandPlayer;

    modport master (
        input  turnIndicator, activePlayer, accept,
        output ready, command, commandPlayer
    );

    modport slave (
        output turnIndicator, activePlayer, accept,
        input  ready, command, commandPlayer
    );
endinterface

// File: rtl/user_input_ctrl_key_debouncer.sv
// One active-low pushbutton: 2-flop synchroniser, saturating debounce counter
// and a single-cycle press pulse on the debounced 1->0 transition.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_i,
    output logic level_o,
    output logic press_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchroniser flops idle at the released level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    // Any sample equal to the current level restarts the stability count.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
            press_d = ~sync2_q;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Debounced state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/user_input_ctrl.sv
// Debounced pushbutton front end: issues one tagged gameCommand per turn and holds
// it under ready/accept. Optional idle-turn auto-STAND under USER_INPUT_TIMEOUT_EN.
module user_input_ctrl
    import user_input_ctrl_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] KEY,
    user_input_ctrl_if.master   game
`ifdef USER_INPUT_TIMEOUT_EN
    ,
    output logic                timedOut
`endif
);
    localparam int PLAYER_W = player_width(NUM_PLAYERS);

    if (NUM_KEYS < 2 || NUM_KEYS > MAX_KEYS || DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1)
    begin : g_param_check
        $error("user_input_ctrl: illegal parameter set");
    end

    logic [NUM_KEYS-1:0] level_s;
    logic [NUM_KEYS-1:0] press_s;
    logic [MAX_KEYS-1:0] press4_s;
    logic                all_released_s;
    logic                press_any_s;
    logic                player_change_s;
    logic                timeout_hit_s;
    logic                issue_s;
    logic                hold_load_s;
    gameCommand          decoded_s;
    gameCommand          issue_cmd_s;

    uic_state_t          state_q;
    logic                ready_q;
    gameCommand          command_q;
    logic [PLAYER_W-1:0] player_q;
    logic [PLAYER_W-1:0] cmd_player_q;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .reset   (reset),
            .key_i   (KEY[k]),
            .level_o (level_s[k]),
            .press_o (press_s[k])
        );
    end

    // Pad to the full key set so absent keys never produce a pulse.
    always_comb begin
        press4_s                 = '0;
        press4_s[NUM_KEYS-1:0]   = press_s;
    end

    assign all_released_s  = &level_s;
    assign press_any_s     = |press_s;
    assign player_change_s = (game.activePlayer != player_q);
    assign decoded_s       = decode_press(press4_s);
    assign issue_s         = press_any_s | timeout_hit_s;
    assign issue_cmd_s     = press_any_s ? decoded_s : STAND;
    assign hold_load_s     = (state_q == ST_ARMED) & game.turnIndicator & issue_s;

`ifdef USER_INPUT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            timed_out_q;

    assign timeout_hit_s = (state_q == ST_ARMED) && (to_cnt_q == TO_LAST);

    // Idle-turn counter; a seat change restarts the new player's allowance.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if (state_q != ST_ARMED || !game.turnIndicator ||
                     player_change_s || timeout_hit_s) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // Flags commands that were generated by the timeout rather than a key.
    always_ff @(posedge clk) begin
        if (reset) begin
            timed_out_q <= 1'b0;
        end else if (hold_load_s) begin
            timed_out_q <= ~press_any_s;
        end else if (state_q != ST_HOLD || !game.turnIndicator || game.accept) begin
            timed_out_q <= 1'b0;
        end else begin
            timed_out_q <= timed_out_q;
        end
    end

    assign timedOut = timed_out_q;
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Turn FSM; a turn drop in ARMED takes priority over a same-cycle press.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            command_q    <= NONE;
            player_q     <= '0;
            cmd_player_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q   <= 1'b0;
                    command_q <= NONE;
                    if (game.turnIndicator && all_released_s) begin
                        state_q  <= ST_ARMED;
                        player_q <= game.activePlayer;
                    end
                end
                ST_ARMED: begin
                    if (!game.turnIndicator) begin
                        state_q <= ST_IDLE;
                    end else if (hold_load_s) begin
                        state_q      <= ST_HOLD;
                        ready_q      <= 1'b1;
                        command_q    <= issue_cmd_s;
                        cmd_player_q <= player_q;
                    end else if (player_change_s) begin
                        player_q <= game.activePlayer;
                    end
                end
                ST_HOLD: begin
                    if (!game.turnIndicator) begin
                        state_q   <= ST_IDLE;
                        ready_q   <= 1'b0;
                        command_q <= NONE;
                    end else if (game.accept) begin
                        state_q   <= ST_RELEASE;
                        ready_q   <= 1'b0;
                        command_q <= NONE;
                    end
                end
                ST_RELEASE: begin
                    ready_q   <= 1'b0;
                    command_q <= NONE;
                    if (all_released_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    ready_q   <= 1'b0;
                    command_q <= NONE;
                end
            endcase
        end
    end

    assign game.ready         = ready_q;
    assign game.command       = command_q;
    assign game.commandPlayer = cmd_player_q;

endmodule

// File: tb/tb_user_input_ctrl.sv
// Scoreboard bench for user_input_ctrl with short debounce; expected commands are
// queued when a key is driven and compared when ready rises.
module tb_user_input_ctrl;
    import user_input_ctrl_pkg::*;

    localparam int NK = 3;
    localparam int DB = 4;
    localparam int TO = 10;

    typedef struct {
        gameCommand cmd;
        logic [0:0] player;
        logic       to;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [NK-1:0] key;
    logic          timed_out;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   ready_rises = 0;
    logic ready_prev  = 1'b0;

    user_input_ctrl_if #(.PLAYER_W(1)) game_if ();

    user_input_ctrl #(
        .NUM_PLAYERS     (2),
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .KEY      (key),
        .game     (game_if)
`ifdef USER_INPUT_TIMEOUT_EN
        ,
        .timedOut (timed_out)
`endif
    );

`ifndef USER_INPUT_TIMEOUT_EN
    assign timed_out = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input gameCommand c, input logic [0:0] p, input logic t);
        exp_t e;
        e.cmd = c;
        e.player = p;
        e.to = t;
        sb_q.push_back(e);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (game_if.ready) break;
            tick();
        end
        check_val(tag, 32'(game_if.ready), 32'd1);
    endtask

    task automatic do_accept();
        game_if.accept = 1'b1;
        tick();
        game_if.accept = 1'b0;
    endtask

    // Monitor: compare each new command against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (game_if.ready && !ready_prev) begin
            ready_rises++;
            if (sb_q.size() == 0) begin
                check_val("spurious_ready", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("sb_command", 32'(game_if.command), 32'(e.cmd));
                check_val("sb_player", 32'(game_if.commandPlayer), 32'(e.player));
                check_val("sb_timedout", 32'(timed_out), 32'(e.to));
            end
        end
        ready_prev = game_if.ready;
    end

    initial begin
        int r0;
        reset = 1'b1;
        key = '1;
        game_if.turnIndicator = 1'b0;
        game_if.activePlayer = 1'b0;
        game_if.accept = 1'b0;
        repeat (3) tick();
        check_val("rst_ready", 32'(game_if.ready), 32'd0);
        check_val("rst_command", 32'(game_if.command), 32'(NONE));
        check_val("rst_player", 32'(game_if.commandPlayer), 32'd0);
        reset = 1'b0;

        // Clean HIT for player 1, exact 7-cycle latency, key held well past accept.
        game_if.turnIndicator = 1'b1;
        game_if.activePlayer = 1'b1;
        repeat (3) tick();
        key[0] = 1'b0;
        push_exp(HIT, 1'b1, 1'b0);
        repeat (6) tick();
        check_val("lat_6_not_ready", 32'(game_if.ready), 32'd0);
        tick();
        check_val("lat_7_ready", 32'(game_if.ready), 32'd1);
        repeat (5) tick();
        check_val("hold_ready", 32'(game_if.ready), 32'd1);
        check_val("hold_command", 32'(game_if.command), 32'(HIT));
        do_accept();
        check_val("accept_ready_drop", 32'(game_if.ready), 32'd0);
        check_val("accept_cmd_none", 32'(game_if.command), 32'(NONE));
        repeat (57) tick();
        check_val("held_key_one_hit", 32'(ready_rises), 32'd1);
        key = '1;
        repeat (12) tick();
        push_exp(HIT, 1'b1, 1'b0);
        key[0] = 1'b0;
        wait_ready("rehit_ready", 20);
        do_accept();
        key = '1;
        repeat (12) tick();
        check_val("rehit_count", 32'(ready_rises), 32'd2);

        // Bouncing key never settles long enough.
        r0 = ready_rises;
        for (int i = 0; i < 10; i++) begin
            key[0] = ~key[0];
            tick();
            tick();
        end
        key = '1;
        repeat (12) tick();
        check_val("bounce_no_ready", 32'(ready_rises), 32'(r0));
        check_val("bounce_ready_low", 32'(game_if.ready), 32'd0);

        // Simultaneous HIT and STAND: STAND wins.
        key[1:0] = 2'b00;
        push_exp(STAND, 1'b1, 1'b0);
        wait_ready("stand_ready", 20);
        do_accept();
        key = '1;
        repeat (12) tick();

        // Reset in the middle of a debounce, then a full re-debounce.
        key[0] = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_val("midrst_ready", 32'(game_if.ready), 32'd0);
        check_val("midrst_command", 32'(game_if.command), 32'(NONE));
        check_val("midrst_player", 32'(game_if.commandPlayer), 32'd0);
        reset = 1'b0;
        push_exp(HIT, 1'b1, 1'b0);
        repeat (6) tick();
        check_val("redeb_6_not_ready", 32'(game_if.ready), 32'd0);
        tick();
        check_val("redeb_7_ready", 32'(game_if.ready), 32'd1);
        do_accept();
        key = '1;
        repeat (12) tick();

        // Seat change while armed relatches; turn drop in HOLD discards the command.
        game_if.activePlayer = 1'b0;
        repeat (2) tick();
        push_exp(HIT, 1'b0, 1'b0);
        key[0] = 1'b0;
        wait_ready("drop_ready", 20);
        game_if.turnIndicator = 1'b0;
        tick();
        check_val("drop_ready_low", 32'(game_if.ready), 32'd0);
        check_val("drop_cmd_none", 32'(game_if.command), 32'(NONE));
        key = '1;
        repeat (12) tick();

`ifdef USER_INPUT_TIMEOUT_EN
        game_if.activePlayer = 1'b1;
        game_if.turnIndicator = 1'b1;
        push_exp(STAND, 1'b1, 1'b1);
        repeat (10) tick();
        check_val("to_not_yet", 32'(game_if.ready), 32'd0);
        tick();
        check_val("to_ready", 32'(game_if.ready), 32'd1);
        check_val("to_flag", 32'(timed_out), 32'd1);
        do_accept();
        game_if.turnIndicator = 1'b0;
        repeat (4) tick();
`endif

        repeat (3) tick();
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
